// File: rtl/i2c_slave_fsm_pkg.sv
// i2c_slave_fsm_pkg: shared I2C state codes for the master and slave FSMs.
package i2c_slave_fsm_pkg;
  localparam logic [7:0] M_IDLE  = 8'h00;
  localparam logic [7:0] M_START = 8'h01;
  localparam logic [7:0] M_ADDR  = 8'h02;
  localparam logic [7:0] M_DATA  = 8'h03;
  localparam logic [7:0] M_ACK   = 8'h04;
  localparam logic [7:0] M_STOP  = 8'h05;
  localparam logic [7:0] SLV_IDLE       = 8'h10;
  localparam logic [7:0] SLV_ADDRESS    = 8'h11;
  localparam logic [7:0] SLV_ADDR_ACK   = 8'h12;
  localparam logic [7:0] SLV_WRITE_DATA = 8'h13;
  localparam logic [7:0] SLV_WRITE_ACK  = 8'h14;
  localparam logic [7:0] SLV_READ_DATA  = 8'h15;
  localparam logic [7:0] SLV_READ_ACK   = 8'h16;
  localparam logic [7:0] SLV_WAIT_STOP  = 8'h17;
  localparam logic [3:0] BYTE_BITS      = 4'd8;
  typedef enum logic [7:0] {
    S_IDLE       = SLV_IDLE,
    S_ADDRESS    = SLV_ADDRESS,
    S_ADDR_ACK   = SLV_ADDR_ACK,
    S_WRITE_DATA = SLV_WRITE_DATA,
    S_WRITE_ACK  = SLV_WRITE_ACK,
    S_READ_DATA  = SLV_READ_DATA,
    S_READ_ACK   = SLV_READ_ACK,
    S_WAIT_STOP  = SLV_WAIT_STOP
  } slv_state_e;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-flop synchronizer plus history flop with rise/fall detect.
module i2c_sync_edge (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sr_q, sr_d;
  assign sr_d = {sr_q[1:0], d};
  // Resets to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) sr_q <= 3'b111;
    else         sr_q <= sr_d;
  assign q    = sr_q[1];
  assign rise = sr_q[1] & ~sr_q[2];
  assign fall = ~sr_q[1] & sr_q[2];
endmodule

// File: rtl/i2c_slave_fsm.sv
// i2c_slave_fsm: I2C target FSM with address match, byte write/read and open-drain ACK.
module i2c_slave_fsm
  import i2c_slave_fsm_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [7:0] state
);
  logic scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall;
  logic scl_hi2, start_det, stop_det;
  slv_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic oe_q, oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d, busy_q, busy_d;

  i2c_sync_edge u_scl (.clk(clk), .resetN(resetN), .d(scl_in), .q(scl_s), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .resetN(resetN), .d(sda_in), .q(sda_s), .rise(sda_rise), .fall(sda_fall));

  // SCL high in current and previous sample: high now and not a fresh rise.
  assign scl_hi2   = scl_s & ~scl_rise;
  assign start_det = sda_fall & scl_hi2;
  assign stop_det  = sda_rise & scl_hi2;
  assign cnt_inc   = (cnt_q == BYTE_BITS) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (stop_det) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 4'd0;
    end else if (start_det) begin
      state_d = S_ADDRESS;
      oe_d    = 1'b0;
      cnt_d   = 4'd0;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDRESS, S_WRITE_DATA: begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_inc;
          if (state_q == S_WRITE_DATA && cnt_q == 4'd7) begin
            rx_data_d  = {shift_q[6:0], sda_s};
            rx_valid_d = 1'b1;
          end
        end
        S_READ_DATA: cnt_d = cnt_inc;
        S_READ_ACK:  shift_d = {shift_q[6:0], sda_s};
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDRESS:
          if (cnt_q == BYTE_BITS) begin
            state_d = (shift_q[7:1] == SLAVE_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
            oe_d    = (shift_q[7:1] == SLAVE_ADDR);
            busy_d  = busy_q | (shift_q[7:1] == SLAVE_ADDR);
          end
        S_WRITE_DATA:
          if (cnt_q == BYTE_BITS) begin
            state_d = S_WRITE_ACK;
            oe_d    = 1'b1;
          end
        S_WRITE_ACK: begin
          state_d = S_WRITE_DATA;
          oe_d    = 1'b0;
          cnt_d   = 4'd0;
        end
        S_READ_DATA:
          if (cnt_q == BYTE_BITS) begin
            state_d = S_READ_ACK;
            oe_d    = 1'b0;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        // ADDR_ACK holds R/W in shift_q[0]; READ_ACK holds the master's ACK there.
        S_ADDR_ACK, S_READ_ACK: begin
          cnt_d = 4'd0;
          if ((state_q == S_ADDR_ACK) == shift_q[0]) begin
            state_d  = S_READ_DATA;
            tx_req_d = 1'b1;
            shift_d  = tx_data;
            oe_d     = ~tx_data[7];
          end else begin
            state_d = (state_q == S_ADDR_ACK) ? S_WRITE_DATA : S_WAIT_STOP;
            oe_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end

  assign sda_oe   = oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign state    = state_q;
endmodule

// File: tb/tb_i2c_slave_fsm.sv
// tb_i2c_slave_fsm: directed I2C master transactions with immediate-assertion checks.
module tb_i2c_slave_fsm;
  import i2c_slave_fsm_pkg::*;
  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic scl_in, sda_in, sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data, state;
  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int rx_cnt = 0;
  int oe_cnt = 0;
  int tx_base, rx_base, oe_base;
  logic r;
  logic [7:0] got;

  i2c_slave_fsm #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .resetN(resetN), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always @(negedge clk) begin
    if (tx_req) tx_cnt++;
    if (rx_valid) rx_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic bit_x(input logic b, output logic rb);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    rb = sda_in;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] rd);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_x(b[i], rb);
      rd[i] = rb;
    end
  endtask

  task automatic start_c;
    sda_m = 1'b1;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic stop_c;
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
  endtask

  initial begin
    #2 resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, SLV_IDLE);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    resetN = 1'b1;
    wq();

    // Write 0xA5 to 0x50
    rx_base = rx_cnt;
    start_c();
    check("w_busy_pre", busy, 1'b0);
    send_byte(8'hA0, got);
    check("w_addr_oe", sda_oe, 1'b1);
    check("w_addr_state", state, SLV_ADDR_ACK);
    check("w_busy", busy, 1'b1);
    bit_x(1'b1, r);
    check("w_addr_ack_wire", r, 1'b0);
    send_byte(8'hA5, got);
    check("w_rx_data", rx_data, 8'hA5);
    check("w_rx_pulses", rx_cnt - rx_base, 1);
    check("w_data_state", state, SLV_WRITE_ACK);
    bit_x(1'b1, r);
    check("w_data_ack_wire", r, 1'b0);
    check("w_back_write", state, SLV_WRITE_DATA);
    check("w_oe_rel", sda_oe, 1'b0);
    stop_c();
    check("w_stop_state", state, SLV_IDLE);
    check("w_stop_busy", busy, 1'b0);

    // Address 0x51: ignored
    oe_base = oe_cnt;
    start_c();
    send_byte(8'hA2, got);
    bit_x(1'b1, r);
    check("n_nack_wire", r, 1'b1);
    check("n_state", state, SLV_WAIT_STOP);
    check("n_busy", busy, 1'b0);
    send_byte(8'h00, got);
    stop_c();
    check("n_oe_never", oe_cnt - oe_base, 0);
    check("n_idle", state, SLV_IDLE);
    check("n_busy_end", busy, 1'b0);

    // Read 0x3C then 0xC3, ACK then NACK
    tx_base = tx_cnt;
    tx_data = 8'h3C;
    start_c();
    send_byte(8'hA1, got);
    bit_x(1'b1, r);
    check("r_addr_ack_wire", r, 1'b0);
    tx_data = 8'hC3;
    send_byte(8'hFF, got);
    check("r_byte0", got, 8'h3C);
    check("r_ack_state", state, SLV_READ_ACK);
    bit_x(1'b0, r);
    send_byte(8'hFF, got);
    check("r_byte1", got, 8'hC3);
    bit_x(1'b1, r);
    check("r_tx_pulses", tx_cnt - tx_base, 2);
    check("r_nack_oe", sda_oe, 1'b0);
    check("r_nack_state", state, SLV_WAIT_STOP);
    stop_c();
    check("r_stop_state", state, SLV_IDLE);

    // Repeated START after 4 data bits of a write
    rx_base = rx_cnt;
    tx_data = 8'h5A;
    start_c();
    send_byte(8'hA0, got);
    bit_x(1'b1, r);
    bit_x(1'b1, r);
    bit_x(1'b0, r);
    bit_x(1'b1, r);
    bit_x(1'b0, r);
    start_c();
    check("rs_state", state, SLV_ADDRESS);
    check("rs_oe", sda_oe, 1'b0);
    send_byte(8'hA1, got);
    check("rs_addr_oe", sda_oe, 1'b1);
    bit_x(1'b1, r);
    check("rs_ack_wire", r, 1'b0);
    send_byte(8'hFF, got);
    check("rs_byte", got, 8'h5A);
    bit_x(1'b1, r);
    check("rs_no_rx", rx_cnt - rx_base, 0);
    stop_c();

    // Reset while driving the write ACK
    start_c();
    send_byte(8'hA0, got);
    bit_x(1'b1, r);
    send_byte(8'h12, got);
    check("x_state_ack", state, SLV_WRITE_ACK);
    check("x_oe_ack", sda_oe, 1'b1);
    sda_m = 1'b1;
    @(posedge clk);
    #3 resetN = 1'b0;
    #1;
    check("x_oe_in_reset", sda_oe, 1'b0);
    check("x_state_in_reset", state, SLV_IDLE);
    check("x_busy_in_reset", busy, 1'b0);
    repeat (2) @(posedge clk);
    #3 resetN = 1'b1;
    oe_base = oe_cnt;
    bit_x(1'b1, r);
    check("x_no_ack", r, 1'b1);
    send_byte(8'hA0, got);
    bit_x(1'b1, r);
    check("x_no_addr_ack", r, 1'b1);
    check("x_oe_never", oe_cnt - oe_base, 0);
    check("x_idle", state, SLV_IDLE);
    stop_c();
    start_c();
    send_byte(8'hA0, got);
    check("x_fresh_oe", sda_oe, 1'b1);
    bit_x(1'b1, r);
    stop_c();

    // STOP in the middle of READ_DATA
    tx_data = 8'hFF;
    start_c();
    send_byte(8'hA1, got);
    bit_x(1'b1, r);
    bit_x(1'b1, r);
    bit_x(1'b1, r);
    bit_x(1'b1, r);
    check("s_state_read", state, SLV_READ_DATA);
    check("s_busy_read", busy, 1'b1);
    stop_c();
    check("s_idle", state, SLV_IDLE);
    check("s_oe", sda_oe, 1'b0);
    check("s_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
